// File: rtl/if_de_stage_if.sv
// Bus between the fetch/decode front end and its neighbours (hazard unit, EX redirect, I-memory).
// The slave modport is the stage's view; the master modport is the environment driving it.
interface if_de_stage_if #(
  parameter int XLEN = 32
);
  logic            stall_de;
  logic            flush_de;
  logic [XLEN-1:0] branch_target_ex;
  logic [31:0]     inst_fe;
  logic [XLEN-1:0] pc_fe;
  logic [31:0]     inst_de;
  logic [XLEN-1:0] pc_de;
  logic [XLEN-1:0] pc4_de;
  logic            valid_de;
  logic [4:0]      rs1_de;
  logic [4:0]      rs2_de;
  logic            bubble_ex;
  logic [15:0]     stall_count;
  logic            stall_timeout;

  modport master (
    output stall_de, flush_de, branch_target_ex, inst_fe,
    input  pc_fe, inst_de, pc_de, pc4_de, valid_de, rs1_de, rs2_de,
           bubble_ex, stall_count, stall_timeout
  );

  modport slave (
    input  stall_de, flush_de, branch_target_ex, inst_fe,
    output pc_fe, inst_de, pc_de, pc4_de, valid_de, rs1_de, rs2_de,
           bubble_ex, stall_count, stall_timeout
  );
endinterface

// File: rtl/if_de_stage.sv
// RISC-V fetch front end: PC register, IF/DE pipeline register, next-PC selection,
// stall/flush handling and stall performance/watchdog counters.
module if_de_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP       = 32'h0000_0013,
  parameter int              MAX_STALL = 15
) (
  input logic           clk,
  input logic           rst_n,
  if_de_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_STALL = 2'd1,
    MODE_FLUSH = 2'd2
  } mode_t;

  localparam int TIMEOUT_AT = MAX_STALL + 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  mode_t           mode;
  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] pc_plus4_p0;
  logic [XLEN-1:0] target_p0;
  logic [31:0]     inst_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] pc4_p1;
  logic            vld_p1;
  logic [4:0]      consec_p1;
  logic [4:0]      consec_inc;
  logic [15:0]     stall_cnt_p1;
  logic            timeout_p1;
  // Redirect targets are forced word-aligned, so the low two bits are deliberately dropped.
  logic            unused_target_lsb;

  assign unused_target_lsb = ^bus.branch_target_ex[1:0];

  always_comb begin
    mode = MODE_RUN;
    if (bus.flush_de)      mode = MODE_FLUSH;
    else if (bus.stall_de) mode = MODE_STALL;
  end

  assign pc_plus4_p0 = pc_p0 + XLEN'(4);
  assign target_p0   = {bus.branch_target_ex[XLEN-1:2], 2'b00};
  assign consec_inc  = sat_inc5(consec_p1);

  // Stage p0 -> p1: fetch address and IF/DE register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0   <= RESET_PC;
      inst_p1 <= NOP;
      pc_p1   <= '0;
      pc4_p1  <= '0;
      vld_p1  <= 1'b0;
    end else begin
      case (mode)
        MODE_FLUSH: begin
          pc_p0   <= target_p0;
          inst_p1 <= NOP;
          pc_p1   <= '0;
          pc4_p1  <= '0;
          vld_p1  <= 1'b0;
        end
        MODE_RUN: begin
          pc_p0   <= pc_plus4_p0;
          inst_p1 <= bus.inst_fe;
          pc_p1   <= pc_p0;
          pc4_p1  <= pc_plus4_p0;
          vld_p1  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stall counters: total stalled cycles and consecutive-stall watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consec_p1    <= '0;
      stall_cnt_p1 <= '0;
      timeout_p1   <= 1'b0;
    end else if (mode == MODE_STALL) begin
      consec_p1    <= consec_inc;
      stall_cnt_p1 <= sat_inc16(stall_cnt_p1);
      if (32'(consec_inc) >= 32'(TIMEOUT_AT)) timeout_p1 <= 1'b1;
    end else begin
      consec_p1 <= '0;
    end
  end

  assign bus.pc_fe         = pc_p0;
  assign bus.inst_de       = inst_p1;
  assign bus.pc_de         = pc_p1;
  assign bus.pc4_de        = pc4_p1;
  assign bus.valid_de      = vld_p1;
  assign bus.rs1_de        = inst_p1[19:15];
  assign bus.rs2_de        = inst_p1[24:20];
  assign bus.bubble_ex     = bus.stall_de | bus.flush_de;
  assign bus.stall_count   = stall_cnt_p1;
  assign bus.stall_timeout = timeout_p1;

endmodule

// File: tb/tb_if_de_stage.sv
// Directed bench for if_de_stage: a behavioural model pushes expected DE state per cycle
// into a scoreboard queue, which is popped and compared after each active edge.
module tb_if_de_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc_fe;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        vld;
    logic [15:0] cnt;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];

  logic [31:0] m_pc_fe, m_inst, m_pc, m_pc4;
  logic        m_vld, m_to;
  logic [15:0] m_cnt;
  int          m_consec;

  always #5 clk = ~clk;

  if_de_stage_if #(.XLEN(32)) bus ();
  if_de_stage_if #(.XLEN(32)) bus2 ();

  if_de_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP(NOP), .MAX_STALL(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  if_de_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .NOP(NOP), .MAX_STALL(15)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2.slave)
  );

  // Instruction memory: each word holds its own address
  assign bus.inst_fe  = bus.pc_fe;
  assign bus2.inst_fe = bus2.pc_fe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc_fe = 32'h0; m_inst = NOP; m_pc = 32'h0; m_pc4 = 32'h0;
    m_vld = 1'b0; m_to = 1'b0; m_cnt = 16'h0; m_consec = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc_fe"},    bus.pc_fe, 32'h0);
    chk({tag, "_inst_de"},  bus.inst_de, NOP);
    chk({tag, "_pc_de"},    bus.pc_de, 32'h0);
    chk({tag, "_pc4_de"},   bus.pc4_de, 32'h0);
    chk({tag, "_valid_de"}, 32'(bus.valid_de), 32'h0);
    chk({tag, "_count"},    32'(bus.stall_count), 32'h0);
    chk({tag, "_timeout"},  32'(bus.stall_timeout), 32'h0);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic s, input logic f, input logic [31:0] tgt);
    exp_t e;
    bus.stall_de = s; bus.flush_de = f; bus.branch_target_ex = tgt;
    #1;
    chk("bubble_ex", 32'(bus.bubble_ex), 32'(s | f));
    if (f) begin
      m_pc_fe = {tgt[31:2], 2'b00};
      m_inst = NOP; m_pc = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0; m_consec = 0;
    end else if (s) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_consec < 31) m_consec++;
      if (m_consec >= 16) m_to = 1'b1;
    end else begin
      m_inst = m_pc_fe; m_pc = m_pc_fe; m_pc4 = m_pc_fe + 32'd4;
      m_pc_fe = m_pc_fe + 32'd4; m_vld = 1'b1; m_consec = 0;
    end
    sb.push_back('{m_pc_fe, m_inst, m_pc, m_pc4, m_vld, m_cnt, m_to});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("pc_fe",         bus.pc_fe, e.pc_fe);
    chk("inst_de",       bus.inst_de, e.inst);
    chk("pc_de",         bus.pc_de, e.pc);
    chk("pc4_de",        bus.pc4_de, e.pc4);
    chk("valid_de",      32'(bus.valid_de), 32'(e.vld));
    chk("rs1_de",        32'(bus.rs1_de), 32'(e.inst[19:15]));
    chk("rs2_de",        32'(bus.rs2_de), 32'(e.inst[24:20]));
    chk("stall_count",   32'(bus.stall_count), 32'(e.cnt));
    chk("stall_timeout", 32'(bus.stall_timeout), 32'(e.to));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    bus.stall_de = 1'b0; bus.flush_de = 1'b0; bus.branch_target_ex = 32'h0;
    bus2.stall_de = 1'b0; bus2.flush_de = 1'b0; bus2.branch_target_ex = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    bus.stall_de = 1'b1; #1;
    chk("bubble_in_reset_hi", 32'(bus.bubble_ex), 32'h1);
    bus.stall_de = 1'b0; #1;
    chk("bubble_in_reset_lo", 32'(bus.bubble_ex), 32'h0);

    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("run_pc_fe_8", bus.pc_fe, 32'h8);

    step(1, 0, 0);
    step(1, 0, 0);
    chk("stall_pc_hold", bus.pc_fe, 32'h8);
    chk("stall_inst_hold", bus.inst_de, 32'h4);
    chk("stall_count_2", 32'(bus.stall_count), 32'd2);

    repeat (6) step(0, 0, 0);
    chk("run_pc_fe_20", bus.pc_fe, 32'h20);

    step(0, 1, 32'h103);
    chk("flush_pc_fe", bus.pc_fe, 32'h100);
    chk("flush_inst_nop", bus.inst_de, NOP);
    chk("flush_rs1_zero", 32'(bus.rs1_de), 32'h0);
    step(0, 0, 0);
    chk("target_inst_de", bus.inst_de, 32'h100);
    chk("target_pc_de", bus.pc_de, 32'h100);

    step(1, 1, 32'h40);
    chk("flush_stall_pc", bus.pc_fe, 32'h40);
    chk("flush_stall_count", 32'(bus.stall_count), 32'd2);
    step(0, 0, 0);

    repeat (15) step(1, 0, 0);
    chk("stall15_no_timeout", 32'(bus.stall_timeout), 32'h0);
    step(0, 0, 0);
    repeat (16) step(1, 0, 0);
    chk("stall16_timeout", 32'(bus.stall_timeout), 32'h1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("timeout_sticky", 32'(bus.stall_timeout), 32'h1);

    step(0, 1, 32'h0123_8001);
    step(0, 0, 0);
    chk("rs1_field", 32'(bus.rs1_de), 32'd7);
    chk("rs2_field", 32'(bus.rs2_de), 32'd18);

    bus.stall_de = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midstall_reset");
    chk("midstall_bubble", 32'(bus.bubble_ex), 32'h1);
    model_reset();
    bus.stall_de = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0);
    chk("post_reset_pc_fe", bus.pc_fe, 32'h4);

    chk("wrap_reset_pc", bus2.pc_fe, 32'hFFFF_FFF8);
    @(negedge clk) rst2_n = 1'b1;
    @(posedge clk); #1;
    chk("wrap_pc_fe_1", bus2.pc_fe, 32'hFFFF_FFFC);
    chk("wrap_inst_de_1", bus2.inst_de, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk("wrap_pc_fe_2", bus2.pc_fe, 32'h0000_0000);
    chk("wrap_pc_de_2", bus2.pc_de, 32'hFFFF_FFFC);
    chk("wrap_pc4_de_2", bus2.pc4_de, 32'h0000_0000);
    @(posedge clk); #1;
    chk("wrap_pc_fe_3", bus2.pc_fe, 32'h0000_0004);
    chk("wrap_pc_de_3", bus2.pc_de, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/if_de_stage.md
# if_de_stage

Fetch-side front end of the pipelined RISC-V core. Holds the program counter and the IF/DE pipeline register, and generates the next PC. It consumes the hazard unit's load-use stall and the EX-stage branch redirect, and turns them into PC hold, IF/DE hold/flush and a DE/EX bubble request. It also supplies `rs1_de`/`rs2_de`, which the hazard unit compares, and keeps stall performance/watchdog counters.

## Interface
- `XLEN`, 32, PC and data width.
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset.
- `NOP`, 32'h0000_0013, instruction injected on flush (`addi x0,x0,0`).
- `MAX_STALL`, 15, consecutive stall cycles tolerated before `stall_timeout`.
- `clk  in  1  single clock; all state updates on rising edge.`
- `rst_n  in  1  reset, asynchronous assert, active-low.`
- `stall_de  in  1  hazard-unit Result; hold PC and IF/DE this cycle.`
- `flush_de  in  1  branch/jump taken in EX; redirect and kill IF/DE.`
- `branch_target_ex  in  XLEN  redirect address, valid when flush_de=1.`
- `inst_fe  in  32  instruction memory read data for pc_fe (combinational ROM).`
- `pc_fe  out  XLEN  current fetch address to instruction memory.`
- `inst_de  out  32  registered instruction in DE.`
- `pc_de  out  XLEN  PC of inst_de.`
- `pc4_de  out  XLEN  pc_de+4 (link value).`
- `valid_de  out  1  inst_de is a real fetched instruction.`
- `rs1_de  out  5  inst_de[19:15], to hazard unit.`
- `rs2_de  out  5  inst_de[24:20], to hazard unit.`
- `bubble_ex  out  1  zero DE/EX control fields next edge.`
- `stall_count  out  16  saturating count of stalled cycles.`
- `stall_timeout  out  1  sticky: stall exceeded MAX_STALL consecutive cycles.`

## Operation
- Per-cycle mode, priority flush > stall > run:
  - FLUSH (`flush_de=1`, `stall_de` ignored): `pc_fe <= {branch_target_ex[XLEN-1:2],2'b00}`; `inst_de <= NOP`; `pc_de <= 0`; `pc4_de <= 0`; `valid_de <= 0`.
  - STALL (`stall_de=1`, `flush_de=0`): `pc_fe`, `inst_de`, `pc_de`, `pc4_de` and `valid_de` hold. `stall_count` increments.
  - RUN: `pc_fe <= pc_fe+4`; `inst_de <= inst_fe`; `pc_de <= pc_fe`; `pc4_de <= pc_fe+4`; `valid_de <= 1`.
- `bubble_ex = stall_de | flush_de`, combinational; the DE/EX register inserts a NOP when this is set.
- `rs1_de`/`rs2_de` are combinational slices of `inst_de`. After a flush they are 0. A write of x0 by the downstream hazard unit is harmless because x0 has no RD writes.
- All additions are modulo 2^XLEN. A PC of 0xFFFF_FFFC wraps to 0 with no flag.
- Consecutive-stall counter, internal 5 bits:
  - Increments in STALL and saturates at 31.
  - Clears in RUN or FLUSH.
  - When it reaches `MAX_STALL+1`, `stall_timeout` sets and stays set until reset.
- `stall_count` saturates at 16'hFFFF and does not wrap.

## Timing
- Reset (`rst_n=0`, asynchronous) values: `pc_fe=RESET_PC`, `inst_de=NOP`, `pc_de=0`, `pc4_de=0`, `valid_de=0`, `stall_count=0`, `stall_timeout=0`, internal counter 0.
- `bubble_ex` follows its inputs even during reset.
- Reset assertion mid-stall or mid-flush overrides everything immediately.
- After reset deasserts:
  - The first edge loads `inst_de = mem[RESET_PC]` and sets `pc_fe=RESET_PC+4`.
  - Fetch-to-DE latency is 1 cycle.
- Redirect penalty:
  - The edge with `flush_de=1` loads the target.
  - The target instruction reaches DE one edge later.
  - Two instructions are killed: the one in DE and the one being fetched.
- Stall of N cycles delays DE by exactly N cycles and produces N DE/EX bubbles.
- Simultaneous `stall_de=1` and `flush_de=1` is treated as FLUSH. `stall_count` does not increment.

## Test plan
- Reset then 4 RUN cycles with memory word = address: `pc_fe` goes 0→4→8→C→10. `inst_de`/`pc_de` trail by one cycle. `pc4_de=pc_de+4`. `valid_de` becomes 1 after the 1st edge.
- Stall at pc_fe=8 for 2 cycles: `pc_fe` stays 8 and `inst_de` stays mem[4] for 2 edges. `bubble_ex=1` both cycles. `stall_count=2`. The stream then resumes with mem[8].
- `flush_de=1` with target 0x103 at pc_fe=0x20: next edge gives `pc_fe=0x100`, `inst_de=0x13`, `valid_de=0`, `rs1_de=rs2_de=0`. The following edge gives `inst_de=mem[0x100]`, `pc_de=0x100`.
- Flush and stall asserted together: the flush is taken, `stall_count` is unchanged, and `bubble_ex=1`.
- Hold stall for 16 cycles with MAX_STALL=15: `stall_timeout` rises on the 16th stalled edge and remains 1 after the stall releases. A stall of 15 cycles leaves it 0.
- PC wrap and reset mid-stall:
  - `RESET_PC=32'hFFFF_FFF8`, 3 RUN cycles: `pc_fe` goes FFF8→FFFC→0000→0004.
  - Assert `rst_n=0` during a stall: outputs take reset values without waiting for a clock edge.
